// File: rtl/fft4_pkg.sv
// fft4_pkg: shared types and constants for the streaming 4-point FFT.
package fft4_pkg;
   localparam int N = 4;
   typedef enum logic [1:0] {LOAD, S1, S2, UNLOAD} state_t;
   typedef enum logic [1:0] {TW_NONE, TW_NEG_J, TW_POS_J} tw_t;
endpackage

// File: rtl/fft4_bfly.sv
// fft4_bfly: complex butterfly p = a + t*b, m = a - t*b with t in {1, -j, +j}, WIDTH+1 growth.
// FFT4_SCALE_EN: every result is floor-halved and overflow is never flagged.
module fft4_bfly
   import fft4_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic signed [WIDTH-1:0] i_a_re,
   input  logic signed [WIDTH-1:0] i_a_im,
   input  logic signed [WIDTH-1:0] i_b_re,
   input  logic signed [WIDTH-1:0] i_b_im,
   input  tw_t                     i_tw,
   output logic signed [WIDTH-1:0] o_p_re,
   output logic signed [WIDTH-1:0] o_p_im,
   output logic signed [WIDTH-1:0] o_m_re,
   output logic signed [WIDTH-1:0] o_m_im,
   output logic                    o_ovf
);
   logic signed [WIDTH-1:0] w_xr, w_xi;
   logic signed [WIDTH:0]   w_sr, w_dr, w_si, w_di, w_pr, w_pi, w_mr, w_mi;
   logic                    w_swap_r, w_swap_i;
   // A twiddle of +/-j swaps b's components; the sign lands by swapping sum and difference.
   always_comb begin
      w_xr     = (i_tw == TW_NONE) ? i_b_re : i_b_im;
      w_xi     = (i_tw == TW_NONE) ? i_b_im : i_b_re;
      w_sr     = i_a_re + w_xr;
      w_dr     = i_a_re - w_xr;
      w_si     = i_a_im + w_xi;
      w_di     = i_a_im - w_xi;
      w_swap_r = (i_tw == TW_POS_J);
      w_swap_i = (i_tw == TW_NEG_J);
      w_pr     = w_swap_r ? w_dr : w_sr;
      w_mr     = w_swap_r ? w_sr : w_dr;
      w_pi     = w_swap_i ? w_di : w_si;
      w_mi     = w_swap_i ? w_si : w_di;
   end
`ifdef FFT4_SCALE_EN
   assign o_p_re = w_pr[WIDTH:1];
   assign o_p_im = w_pi[WIDTH:1];
   assign o_m_re = w_mr[WIDTH:1];
   assign o_m_im = w_mi[WIDTH:1];
   assign o_ovf  = 1'b0;
`else
   assign o_p_re = w_pr[WIDTH-1:0];
   assign o_p_im = w_pi[WIDTH-1:0];
   assign o_m_re = w_mr[WIDTH-1:0];
   assign o_m_im = w_mi[WIDTH-1:0];
   assign o_ovf  = (w_pr[WIDTH] ^ w_pr[WIDTH-1]) | (w_pi[WIDTH] ^ w_pi[WIDTH-1]) |
                   (w_mr[WIDTH] ^ w_mr[WIDTH-1]) | (w_mi[WIDTH] ^ w_mi[WIDTH-1]);
`endif
endmodule

// File: rtl/fft4_stream.sv
// fft4_stream: streaming 4-point radix-2 DIT forward/inverse DFT with valid/ready in and out.
// Define FFT4_SCALE_EN to halve every stage (true IDFT, ovf tied low).
module fft4_stream
   import fft4_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_real,
   input  logic signed [WIDTH-1:0] in_imag,
   input  logic                    in_inverse,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] out_real,
   output logic signed [WIDTH-1:0] out_imag,
   output logic [1:0]              out_index,
   output logic                    out_last,
   output logic                    ovf
);
   typedef struct packed {
      logic signed [WIDTH-1:0] re;
      logic signed [WIDTH-1:0] im;
   } cplx_t;
   state_t                  r_state, w_state_nxt;
   cplx_t                   r_x [N];
   logic [1:0]              r_idx;
   logic                    r_inv, r_ovf, w_in_fire, w_out_fire;
   tw_t                     w_tw;
   logic signed [WIDTH-1:0] w_pr [N];
   logic signed [WIDTH-1:0] w_pi [N];
   logic signed [WIDTH-1:0] w_mr [N];
   logic signed [WIDTH-1:0] w_mi [N];
   logic [N-1:0]            w_bovf;
   assign in_ready   = (r_state == LOAD);
   assign out_valid  = (r_state == UNLOAD);
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = out_valid && out_ready;
   assign w_tw       = r_inv ? TW_POS_J : TW_NEG_J;
   // The frame buffer is reused in place: samples, then stage-1 terms, then bins.
   // Butterflies 0/1 form stage 1 and 2/3 form stage 2; all read pairs (k, k+2).
   genvar i;
   generate
      for (i = 0; i < N; i++) begin : g_bfly
         fft4_bfly #(.WIDTH(WIDTH)) u_bfly (
            .i_a_re (r_x[i % 2].re),
            .i_a_im (r_x[i % 2].im),
            .i_b_re (r_x[i % 2 + 2].re),
            .i_b_im (r_x[i % 2 + 2].im),
            .i_tw   ((i == 3) ? w_tw : TW_NONE),
            .o_p_re (w_pr[i]),
            .o_p_im (w_pi[i]),
            .o_m_re (w_mr[i]),
            .o_m_im (w_mi[i]),
            .o_ovf  (w_bovf[i])
         );
      end
   endgenerate
   always_comb begin
      w_state_nxt = (w_in_fire && r_idx == 2'd3)  ? S1     :
                    (r_state == S1)               ? S2     :
                    (r_state == S2)               ? UNLOAD :
                    (w_out_fire && r_idx == 2'd3) ? LOAD   : r_state;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= LOAD;
         r_idx   <= '0;
         r_inv   <= 1'b0;
         r_ovf   <= 1'b0;
         for (int k = 0; k < N; k++) r_x[k] <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_in_fire || w_out_fire) r_idx <= r_idx + 2'd1;
         if (w_in_fire) r_x[r_idx] <= {in_real, in_imag};
         if (w_in_fire && r_idx == 2'd0) r_inv <= in_inverse;
         if (r_state == S1) begin
            r_x[0] <= {w_pr[0], w_pi[0]};
            r_x[1] <= {w_mr[0], w_mi[0]};
            r_x[2] <= {w_pr[1], w_pi[1]};
            r_x[3] <= {w_mr[1], w_mi[1]};
            r_ovf  <= r_ovf | (|w_bovf[1:0]);
         end
         if (r_state == S2) begin
            r_x[0] <= {w_pr[2], w_pi[2]};
            r_x[1] <= {w_pr[3], w_pi[3]};
            r_x[2] <= {w_mr[2], w_mi[2]};
            r_x[3] <= {w_mr[3], w_mi[3]};
            r_ovf  <= r_ovf | (|w_bovf[3:2]);
         end
         if (w_out_fire && r_idx == 2'd3) r_ovf <= 1'b0;
      end
   end
   assign out_real  = out_valid ? r_x[r_idx].re : '0;
   assign out_imag  = out_valid ? r_x[r_idx].im : '0;
   assign out_index = out_valid ? r_idx : 2'd0;
   assign out_last  = out_valid && (r_idx == 2'd3);
   assign ovf       = r_ovf;
endmodule

// File: tb/tb_fft4_stream.sv
// tb_fft4_stream: directed frames checked against a DFT-level reference model and hand literals.
module tb_fft4_stream;
   localparam int W = 8;
   logic clk = 0, rst = 1, in_valid = 0, in_inverse = 0, out_ready = 1;
   logic signed [W-1:0] in_real = 0, in_imag = 0;
   logic in_ready, out_valid, out_last, ovf;
   logic signed [W-1:0] out_real, out_imag;
   logic [1:0] out_index;
   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   fft4_stream #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_real(in_real), .in_imag(in_imag), .in_inverse(in_inverse),
      .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real),
      .out_imag(out_imag), .out_index(out_index), .out_last(out_last), .ovf(ovf)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: the 4-point DFT as two radix-2 stages at integer precision.
   int s_re[4], s_im[4], s_n = 0;
   bit s_inv, m_ov;
   int q_re[$], q_im[$];
   bit q_ov[$];
   int got_re[4], got_im[4], got_n, got_ov;
   int cyc = 0, t_acc = 0;
   bit first_pend = 0, stalled = 0;
   int sv_re, sv_im, sv_idx, sv_last;

   function automatic int fit(input int s);
      int w;
`ifdef FFT4_SCALE_EN
      w = s >>> 1;
`else
      w = ((s + (1 << (W - 1))) & ((1 << W) - 1)) - (1 << (W - 1));
      if (w != s) m_ov = 1;
`endif
      return w;
   endfunction

   function automatic void model_frame();
      int a_re[4], a_im[4], x_re[4], x_im[4];
      m_ov = 0;
      a_re[0] = fit(s_re[0] + s_re[2]); a_im[0] = fit(s_im[0] + s_im[2]);
      a_re[1] = fit(s_re[0] - s_re[2]); a_im[1] = fit(s_im[0] - s_im[2]);
      a_re[2] = fit(s_re[1] + s_re[3]); a_im[2] = fit(s_im[1] + s_im[3]);
      a_re[3] = fit(s_re[1] - s_re[3]); a_im[3] = fit(s_im[1] - s_im[3]);
      x_re[0] = fit(a_re[0] + a_re[2]); x_im[0] = fit(a_im[0] + a_im[2]);
      x_re[2] = fit(a_re[0] - a_re[2]); x_im[2] = fit(a_im[0] - a_im[2]);
      x_re[1] = fit(s_inv ? a_re[1] - a_im[3] : a_re[1] + a_im[3]);
      x_im[1] = fit(s_inv ? a_im[1] + a_re[3] : a_im[1] - a_re[3]);
      x_re[3] = fit(s_inv ? a_re[1] + a_im[3] : a_re[1] - a_im[3]);
      x_im[3] = fit(s_inv ? a_im[1] - a_re[3] : a_im[1] + a_re[3]);
      for (int k = 0; k < 4; k++) begin
         q_re.push_back(x_re[k]);
         q_im.push_back(x_im[k]);
         q_ov.push_back(m_ov);
      end
   endfunction

   always @(negedge clk) begin
      int k, er, ei;
      bit eo;
      cyc++;
      if (rst) begin
         s_n = 0; q_re.delete(); q_im.delete(); q_ov.delete();
         stalled = 0; first_pend = 0;
      end else begin
         if (out_valid) begin
            chk("in_ready_in_unload", in_ready, 0);
            if (first_pend) begin
               chk("latency", cyc - t_acc, 3);
               first_pend = 0;
            end
            if (stalled) begin
               chk("hold_re", out_real, sv_re);
               chk("hold_im", out_imag, sv_im);
               chk("hold_idx", out_index, sv_idx);
               chk("hold_last", out_last, sv_last);
            end
            stalled = !out_ready;
            sv_re = out_real; sv_im = out_imag; sv_idx = out_index; sv_last = out_last;
            if (out_ready) begin
               chk("bin_expected", q_re.size() > 0, 1);
               if (q_re.size() > 0) begin
                  k = 4 - q_re.size();
                  er = q_re.pop_front(); ei = q_im.pop_front(); eo = q_ov.pop_front();
                  chk($sformatf("bin%0d_re", k), out_real, er);
                  chk($sformatf("bin%0d_im", k), out_imag, ei);
                  chk($sformatf("bin%0d_index", k), out_index, k);
                  chk($sformatf("bin%0d_last", k), out_last, k == 3);
                  chk($sformatf("bin%0d_ovf", k), ovf, eo);
                  got_re[k] = out_real; got_im[k] = out_imag; got_n++;
                  if (k == 0) got_ov = ovf;
               end
            end
         end else stalled = 0;
         if (in_valid && in_ready) begin
            s_re[s_n] = in_real; s_im[s_n] = in_imag;
            if (s_n == 0) s_inv = in_inverse;
            s_n++;
            if (s_n == 4) begin
               model_frame();
               s_n = 0; t_acc = cyc; first_pend = 1;
            end
         end
      end
   end

   task automatic do_reset(input int n);
      @(posedge clk); #1;
      rst = 1;
      repeat (n) @(posedge clk);
      #1;
      rst = 0;
   endtask

   // in_inverse toggles on samples 1..3 so only sample 0 may set the frame direction.
   task automatic send_frame(input int re[4], input int im[4], input bit inv, input int ns);
      int n;
      bit ok;
      @(posedge clk); #1;
      for (int i = 0; i < ns; i++) begin
         in_valid = 1; in_real = W'(re[i]); in_imag = W'(im[i]);
         in_inverse = (i == 0) ? inv : !inv;
         n = 0;
         do begin
            @(negedge clk); ok = in_ready;
            @(posedge clk); #1;
            n++;
         end while (!ok && n < 40);
         chk("accept_timeout", n < 40, 1);
      end
      in_valid = 0;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("valid_timeout", n < 20, 1);
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((out_valid || q_re.size() != 0) && n < 60);
      chk("done_timeout", n < 60, 1);
   endtask

   task automatic clear_got();
      for (int k = 0; k < 4; k++) begin
         got_re[k] = 9999; got_im[k] = 9999;
      end
      got_n = 0; got_ov = -1;
   endtask

   task automatic run(input int re[4], input int im[4], input bit inv);
      clear_got();
      send_frame(re, im, inv, 4);
      wait_done();
      chk("bin_count", got_n, 4);
   endtask

   task automatic chk_bins(input string name, input int er[4], input int ei[4]);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("%s_X%0d_re", name, k), got_re[k], er[k]);
         chk($sformatf("%s_X%0d_im", name, k), got_im[k], ei[k]);
      end
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_out_valid"}, out_valid, 0);
      chk({name, "_out_real"}, out_real, 0);
      chk({name, "_out_imag"}, out_imag, 0);
      chk({name, "_out_index"}, out_index, 0);
      chk({name, "_out_last"}, out_last, 0);
      chk({name, "_ovf"}, ovf, 0);
      chk({name, "_in_ready"}, in_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset(2);
      chk_idle("reset");

      run('{1, 2, 3, 4}, '{0, 0, 0, 0}, 0);
`ifndef FFT4_SCALE_EN
      chk_bins("fwd", '{10, -2, -2, -2}, '{0, 2, 0, -2});
      chk("fwd_ovf", got_ov, 0);
`endif

      run('{1, 2, 3, 4}, '{0, 0, 0, 0}, 1);
`ifndef FFT4_SCALE_EN
      chk_bins("inv", '{10, -2, -2, -2}, '{0, -2, 0, 2});
`endif

      run('{40, 0, 0, 0}, '{0, 0, 0, 0}, 0);
`ifdef FFT4_SCALE_EN
      chk_bins("imp", '{10, 10, 10, 10}, '{0, 0, 0, 0});
`else
      chk_bins("imp", '{40, 40, 40, 40}, '{0, 0, 0, 0});
`endif

      run('{127, 127, 127, 127}, '{0, 0, 0, 0}, 0);
`ifndef FFT4_SCALE_EN
      chk("ovf_X0_re", got_re[0], -4);
      chk("ovf_flag", got_ov, 1);
`endif
      run('{1, 2, 3, 4}, '{0, 0, 0, 0}, 0);
      chk("clean_after_ovf", got_ov, 0);

      run('{-128, 100, -50, 127}, '{127, -100, 60, -128}, 1);

      // Backpressure: bin 1 stalls for five cycles.
      out_ready = 0;
      clear_got();
      send_frame('{3, -7, 10, -4}, '{-5, 2, 1, -6}, 0, 4);
      wait_valid();
      @(posedge clk); #1;
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      chk("bp_index", out_index, 1);
      repeat (5) begin
         @(posedge clk); #1;
         chk("bp_held_index", out_index, 1);
         chk("bp_in_ready", in_ready, 0);
      end
      out_ready = 1;
      wait_done();
      chk("bp_bin_count", got_n, 4);
`ifndef FFT4_SCALE_EN
      chk("bp_X0_re", got_re[0], 2);
      chk("bp_X0_im", got_im[0], -8);
      chk("bp_X1_re", got_re[1], 1);
      chk("bp_X1_im", got_im[1], -3);
`endif

      // Reset after two samples, then a clean ramp.
      send_frame('{50, 60, 0, 0}, '{5, 6, 0, 0}, 1, 2);
      do_reset(1);
      chk_idle("midload_reset");
      run('{1, 2, 3, 4}, '{0, 0, 0, 0}, 0);
`ifndef FFT4_SCALE_EN
      chk_bins("after_reset", '{10, -2, -2, -2}, '{0, 2, 0, -2});
`endif

      // Reset while bins are waiting.
      out_ready = 0;
      send_frame('{127, 127, 127, 127}, '{0, 0, 0, 0}, 0, 4);
      wait_valid();
      do_reset(1);
      chk_idle("unload_reset");
      out_ready = 1;
      run('{1, 2, 3, 4}, '{0, 0, 0, 0}, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fft4_stream.md
# fft4_stream

Streaming, parametrised successor to the team's fixed 8-bit, parallel-port 4-point FFT engine. It accepts one complex sample per handshake, buffers a 4-sample frame, and computes a radix-2 decimation-in-time 4-point forward or inverse DFT in two registered stages. It emits the 4 bins in natural order over a valid/ready output stream. It sits between the sample front-end and the spectral post-processing logic.

## Interface
- `WIDTH`, default 8: two's-complement width of every real/imag sample and result.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: input sample valid.
- `in_ready` output 1: block can accept a sample; high only in state LOAD.
- `in_real`, `in_imag` input WIDTH each: signed input sample.
- `in_inverse` input 1: selects inverse transform; sampled only with sample 0 of a frame.
- `out_valid` output 1: output bin valid.
- `out_ready` input 1: downstream accepts the bin.
- `out_real`, `out_imag` output WIDTH each: signed output bin.
- `out_index` output 2: bin number k, 0..3.
- `out_last` output 1: high with bin 3.
- `ovf` output 1: sticky per frame; set if any stage result wrapped.

## Operation
- **Reset (`rst` high at a clock edge):**
  - state=LOAD, load index=0, out_valid=0, out_real=out_imag=0, out_index=0, out_last=0, ovf=0.
  - The frame buffer and inverse flag are cleared.
  - Any partial or in-flight frame is discarded, including when reset arrives mid-LOAD, mid-compute or mid-UNLOAD.
- **LOAD:**
  - Each `in_valid && in_ready` writes x[idx] and increments idx.
  - idx 0 also latches `in_inverse`.
  - Acceptance at idx 3 moves to S1 and wraps idx to 0.
- **S1 (1 cycle), stage 1:**
  - a0=x0+x2, a1=x0−x2, a2=x1+x3, a3=x1−x3.
- **S2 (1 cycle), stage 2:**
  - X0=a0+a2, X2=a0−a2.
  - Forward (twiddle −j): X1=(a1r+a3i, a1i−a3r), X3=(a1r−a3i, a1i+a3r).
  - Inverse (twiddle +j): X1=(a1r−a3i, a1i+a3r), X3=(a1r+a3i, a1i−a3r).
  - No 1/N normalisation is applied unless scaling is enabled.
- **UNLOAD:**
  - Presents X0..X3 in order. Bin k advances only on `out_valid && out_ready`.
  - The handshake on bin 3 returns to LOAD with ovf cleared.
- **Arithmetic:**
  - Each add/sub is computed at WIDTH+1 bits and truncated to WIDTH (two's-complement wrap).
  - ovf is set if the truncated value differs from the WIDTH+1 result.
- **Output stability:** while `out_valid && !out_ready`, out_real, out_imag, out_index and out_last hold stable.
- **Input gating:** `in_valid` is ignored outside LOAD.

## Timing
- Last input accepted at edge t: S1 at t+1, S2 at t+2, out_valid=1 with bin 0 from t+3.
- With out_ready held high, bins 0..3 appear on t+3..t+6, and in_ready=1 from t+7.
- Minimum frame period is 10 cycles (4 load + 2 compute + 4 unload). There is no overlap between frames.
- ovf is valid from t+3 and held through UNLOAD.

## Configuration
- **`FFT4_SCALE_EN` defined:**
  - Every stage output is the WIDTH+1 sum arithmetically shifted right by 1, i.e. floor division.
  - Total gain is 1/4 in both directions, so the inverse is the true IDFT.
  - ovf is tied to 0.
- **`FFT4_SCALE_EN` undefined:** gain is 1 (4 for forward bin 0 of DC), results wrap, and ovf is active.

## Structure
- **`fft4_pkg`:** state enum (LOAD, S1, S2, UNLOAD), the complex sample struct typedef parameterised via WIDTH in the module, and the frame length constant N=4.
- **Sub-module `fft4_bfly`:** one radix-2 add/sub pair with WIDTH+1 growth, optional scale, and overflow output. It is instantiated 4× combinationally, with results registered by the top.

## Test plan
- **Forward ramp, unscaled:** x=[1,2,3,4], in_inverse=0 → X0=10, X1=−2+2j, X2=−2, X3=−2−2j; ovf=0; out_last only on k=3.
- **Inverse ramp, unscaled:** same x, in_inverse=1 → X0=10, X1=−2−2j, X2=−2, X3=−2+2j.
- **Impulse:** x=[40,0,0,0] → all bins 40+0j unscaled; with FFT4_SCALE_EN all bins 10+0j.
- **Overflow (WIDTH=8, unscaled):** x=[127,127,127,127] → X0 real=−4 (508 wrapped), ovf=1; the next clean frame gives ovf=0.
- **Backpressure:** out_ready low for 5 cycles at bin 1 → bin 1 held stable, no bin lost or duplicated, in_ready stays 0 until bin 3 is accepted.
- **Reset mid-frame:** rst after 2 samples, then a full frame x=[1,2,3,4] → output matches the ramp result exactly; out_valid=0 and all outputs 0 in the cycle after reset.
